// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
// Holds the fetch FSM encoding, the PC step and the redirect-target legality check.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_STEP           = 32'd4;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    // A target is fetchable when it is word-aligned and a full word fits in the image.
    function automatic logic target_legal(input logic [31:0] target,
                                          input logic [31:0] imem_bytes);
        return (target[1:0] == 2'b00) && (target <= imem_bytes - PC_STEP);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline latch: holds by default, loads a fetched word, or flushes the valid bit.
// Flush wins over load; flushing leaves the stale word and PC in place.
module if_id_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        valid
);

    logic [31:0] instr_d, instr_q;
    logic [31:0] pc_d,    pc_q;
    logic        valid_d, valid_q;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = instr_in;
            pc_d    = pc_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= 32'h0;
            pc_q    <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc    = pc_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: PC register, next-PC mux, BOOT/RUN/HALT FSM and the IF/ID latch.
// Define FETCH_HALT_DETECT_EN to halt on fetching HALT_WORD; otherwise HALT comes only from AddrFault.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 36,
    parameter logic [31:0] HALT_WORD  = DEFAULT_HALT_WORD
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    input  logic [31:0] InstructionCode,
    output logic [31:0] PC,
    output logic [31:0] IfIdInstr,
    output logic [31:0] IfIdPC,
    output logic        IfIdValid,
    output logic        AddrFault,
    output logic        Halted,
    output logic [1:0]  dbg_state
);

    localparam logic [31:0] IMEM_BYTES_W = 32'(IMEM_BYTES);
    localparam logic [31:0] LAST_PC      = IMEM_BYTES_W - PC_STEP;

`ifdef FETCH_HALT_DETECT_EN
    localparam logic HALT_DETECT = 1'b1;
`else
    localparam logic HALT_DETECT = 1'b0;
`endif

    fetch_state_e state_d, state_q;
    logic [31:0]  pc_d, pc_q;
    logic         fault_d, fault_q;
    logic [31:0]  pc_seq;
    logic         halt_hit;
    logic         ifid_load;
    logic         ifid_flush;

    assign halt_hit = HALT_DETECT && (InstructionCode == HALT_WORD);

    always_comb begin
        pc_seq     = pc_q + PC_STEP;
        if (pc_seq > LAST_PC) begin
            pc_seq = RESET_PC;
        end
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (Redirect) begin
                    ifid_flush = 1'b1;
                    if (target_legal(RedirectTarget, IMEM_BYTES_W)) begin
                        pc_d = RedirectTarget;
                    end else begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end
                end else if (!Stall) begin
                    // The halt word itself is still delivered to decode before the freeze.
                    ifid_load = 1'b1;
                    if (halt_hit) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_seq;
                    end
                end
            end
            HALT: begin
                ifid_flush = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (ifid_load),
        .flush    (ifid_flush),
        .instr_in (InstructionCode),
        .pc_in    (pc_q),
        .instr    (IfIdInstr),
        .pc       (IfIdPC),
        .valid    (IfIdValid)
    );

    assign PC        = pc_q;
    assign AddrFault = fault_q;
    assign Halted    = (state_q == HALT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a vector table for the main sequence plus
// hand-written sequences for reset-in-HALT, out-of-range redirect and halt-word fetch.
module tb_fetch_pc_unit;
  import fetch_pkg::*;

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] InstructionCode;
  logic [31:0] PC;
  logic [31:0] IfIdInstr;
  logic [31:0] IfIdPC;
  logic        IfIdValid;
  logic        AddrFault;
  logic        Halted;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] imem [0:8];
  int          widx;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_ifpc;
    logic        e_valid;
    logic        e_fault;
    logic        e_halt;
    logic        chk_if;
  } vec_t;

  vec_t vec [0:21];

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  fetch_pc_unit dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Stall           (Stall),
    .Redirect        (Redirect),
    .RedirectTarget  (RedirectTarget),
    .InstructionCode (InstructionCode),
    .PC              (PC),
    .IfIdInstr       (IfIdInstr),
    .IfIdPC          (IfIdPC),
    .IfIdValid       (IfIdValid),
    .AddrFault       (AddrFault),
    .Halted          (Halted),
    .dbg_state       (dbg_state)
  );

  // combinational instruction memory
  always_comb begin
    widx = int'(PC >> 2);
    InstructionCode = (PC < 32'd36) ? imem[widx] : 32'h0;
  end

  function automatic logic [31:0] w(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                              input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] ifpc, input logic v, input logic f,
                              input logic h, input logic ci);
    vec_t x;
    x.stall = s;  x.redir = r;  x.tgt = t;
    x.e_pc = pc;  x.e_instr = ins;  x.e_ifpc = ifpc;
    x.e_valid = v;  x.e_fault = f;  x.e_halt = h;  x.chk_if = ci;
    return x;
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // driver: apply inputs, then sample 1ns after the consuming rising edge
  task automatic step(input logic s, input logic r, input logic [31:0] t);
    Stall = s;
    Redirect = r;
    RedirectTarget = t;
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_vals(input int idx);
    check("rst_pc", idx, PC, 32'h0);
    check("rst_instr", idx, IfIdInstr, 32'h0);
    check("rst_ifpc", idx, IfIdPC, 32'h0);
    check("rst_valid", idx, 32'(IfIdValid), 32'h0);
    check("rst_fault", idx, 32'(AddrFault), 32'h0);
    check("rst_halt", idx, 32'(Halted), 32'h0);
    check("rst_state", idx, 32'(dbg_state), 32'(BOOT));
  endtask

  task automatic restart();
    Reset = 1'b0;
    Stall = 1'b0;
    Redirect = 1'b0;
    RedirectTarget = 32'h0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 9; i++) imem[i] = w(i);

    // row: stall redir tgt | pc instr ifpc valid fault halt chk_if
    vec[0]  = mk(0, 1, 32'd20, 32'd0,  32'h0, 32'd0,  0, 0, 0, 1); // BOOT ignores redirect
    vec[1]  = mk(0, 0, 32'd0,  32'd4,  w(0),  32'd0,  1, 0, 0, 1);
    vec[2]  = mk(0, 0, 32'd0,  32'd8,  w(1),  32'd4,  1, 0, 0, 1);
    vec[3]  = mk(0, 0, 32'd0,  32'd12, w(2),  32'd8,  1, 0, 0, 1);
    vec[4]  = mk(1, 0, 32'd0,  32'd12, w(2),  32'd8,  1, 0, 0, 1);
    vec[5]  = mk(1, 0, 32'd0,  32'd12, w(2),  32'd8,  1, 0, 0, 1);
    vec[6]  = mk(1, 0, 32'd0,  32'd12, w(2),  32'd8,  1, 0, 0, 1);
    vec[7]  = mk(0, 0, 32'd0,  32'd16, w(3),  32'd12, 1, 0, 0, 1);
    vec[8]  = mk(0, 0, 32'd0,  32'd20, w(4),  32'd16, 1, 0, 0, 1);
    vec[9]  = mk(0, 0, 32'd0,  32'd24, w(5),  32'd20, 1, 0, 0, 1);
    vec[10] = mk(0, 0, 32'd0,  32'd28, w(6),  32'd24, 1, 0, 0, 1);
    vec[11] = mk(0, 0, 32'd0,  32'd32, w(7),  32'd28, 1, 0, 0, 1);
    vec[12] = mk(0, 0, 32'd0,  32'd0,  w(8),  32'd32, 1, 0, 0, 1); // wrap
    vec[13] = mk(0, 0, 32'd0,  32'd4,  w(0),  32'd0,  1, 0, 0, 1);
    vec[14] = mk(0, 0, 32'd0,  32'd8,  w(1),  32'd4,  1, 0, 0, 1);
    vec[15] = mk(1, 1, 32'd20, 32'd20, 32'h0, 32'd0,  0, 0, 0, 0); // redirect beats stall
    vec[16] = mk(0, 0, 32'd0,  32'd24, w(5),  32'd20, 1, 0, 0, 1);
    vec[17] = mk(0, 1, 32'd32, 32'd32, 32'h0, 32'd0,  0, 0, 0, 0); // last legal target
    vec[18] = mk(0, 0, 32'd0,  32'd0,  w(8),  32'd32, 1, 0, 0, 1);
    vec[19] = mk(0, 1, 32'd22, 32'd0,  32'h0, 32'd0,  0, 1, 1, 0); // misaligned
    vec[20] = mk(0, 0, 32'd0,  32'd0,  32'h0, 32'd0,  0, 1, 1, 0);
    vec[21] = mk(0, 1, 32'd8,  32'd0,  32'h0, 32'd0,  0, 1, 1, 0); // HALT ignores redirect

    Reset = 1'b0;
    Stall = 1'b0;
    Redirect = 1'b0;
    RedirectTarget = 32'h0;
    repeat (3) @(posedge Clk);
    #1;
    check_reset_vals(0);
    Reset = 1'b1;

    for (int i = 0; i < 22; i++) begin
      step(vec[i].stall, vec[i].redir, vec[i].tgt);
      check("pc", i, PC, vec[i].e_pc);
      check("valid", i, 32'(IfIdValid), 32'(vec[i].e_valid));
      check("fault", i, 32'(AddrFault), 32'(vec[i].e_fault));
      check("halted", i, 32'(Halted), 32'(vec[i].e_halt));
      if (vec[i].chk_if) begin
        check("instr", i, IfIdInstr, vec[i].e_instr);
        check("ifpc", i, IfIdPC, vec[i].e_ifpc);
      end
    end
    check("state_halt", 21, 32'(dbg_state), 32'(HALT));

    // asynchronous reset in the middle of HALT
    #2;
    Reset = 1'b0;
    #1;
    check_reset_vals(1);

    // out-of-range redirect
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    step(0, 0, 32'd0);
    check("b_boot_state", 0, 32'(dbg_state), 32'(RUN));
    check("b_boot_pc", 0, PC, 32'd0);
    step(0, 0, 32'd0);
    check("b_pc", 1, PC, 32'd4);
    step(0, 1, 32'd36);
    check("b_pc", 2, PC, 32'd4);
    check("b_fault", 2, 32'(AddrFault), 32'h1);
    check("b_halt", 2, 32'(Halted), 32'h1);
    check("b_valid", 2, 32'(IfIdValid), 32'h0);
    step(0, 0, 32'd0);
    check("b_pc", 3, PC, 32'd4);
    check("b_fault", 3, 32'(AddrFault), 32'h1);
    check("b_valid", 3, 32'(IfIdValid), 32'h0);

    // halt word at address 16
    restart();
    imem[4] = 32'hFFFF_FFFF;
    step(0, 0, 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 32'd0);
    check("c_pc", 0, PC, 32'd16);
    check("c_instr", 0, IfIdInstr, w(3));
    step(0, 0, 32'd0);
    check("c_instr", 1, IfIdInstr, 32'hFFFF_FFFF);
    check("c_ifpc", 1, IfIdPC, 32'd16);
    check("c_valid", 1, 32'(IfIdValid), 32'h1);
`ifdef FETCH_HALT_DETECT_EN
    check("c_pc", 1, PC, 32'd16);
    step(0, 0, 32'd0);
    check("c_valid", 2, 32'(IfIdValid), 32'h0);
    check("c_halt", 2, 32'(Halted), 32'h1);
    check("c_fault", 2, 32'(AddrFault), 32'h0);
    check("c_pc", 2, PC, 32'd16);
    step(0, 1, 32'd8);
    check("c_pc", 3, PC, 32'd16);
    check("c_halt", 3, 32'(Halted), 32'h1);
`else
    check("c_pc", 1, PC, 32'd20);
    check("c_halt", 1, 32'(Halted), 32'h0);
    step(0, 0, 32'd0);
    check("c_pc", 2, PC, 32'd24);
    check("c_instr", 2, IfIdInstr, w(5));
    check("c_ifpc", 2, IfIdPC, 32'd20);
    check("c_valid", 2, 32'(IfIdValid), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch front end that feeds the byte-addressed instruction memory.
- Holds the program counter and drives it to the memory's PC input.
- Captures the returned 32-bit InstructionCode into an IF/ID pipeline register for the decoder.
- Handles stall and redirect (branch/jump) with flush, wrap-around at the end of the memory image, and a fault/halt state.

Parameters:
RESET_PC, 32'h0000_0000, PC value on reset and wrap target; must be word-aligned
IMEM_BYTES, 36, instruction memory size in bytes (highest legal fetch PC = IMEM_BYTES-4)
HALT_WORD, 32'hFFFF_FFFF, encoding treated as halt when FETCH_HALT_DETECT_EN is defined

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Stall  input  1  hold PC and IF/ID contents this cycle
Redirect  input  1  taken branch/jump from a later stage
RedirectTarget  input  32  new PC when Redirect=1
InstructionCode  input  32  word returned combinationally by instruction memory for PC
PC  output  32  current fetch address to instruction memory
IfIdInstr  output  32  latched instruction
IfIdPC  output  32  PC of the latched instruction
IfIdValid  output  1  IfIdInstr/IfIdPC hold a real instruction
AddrFault  output  1  sticky; an illegal redirect target was received
Halted  output  1  state is HALT

Behaviour:
- Reset is asynchronous and active-low. While Reset=0:
  - PC=RESET_PC, IfIdInstr=0, IfIdPC=0, IfIdValid=0, AddrFault=0, Halted=0, state=BOOT.
  - The memory image loads during reset.
- States:
  - BOOT: exactly one cycle after reset release. All registers hold and IfIdValid=0. Next state is RUN unconditionally; Stall and Redirect are ignored.
  - RUN: normal fetch.
  - HALT: PC frozen, IfIdValid=0, Halted=1. HALT is exited only by Reset.
- RUN priority per rising edge: Redirect > Stall > sequential.
- Sequential advance (Stall=0, Redirect=0):
  - IfIdInstr<=InstructionCode, IfIdPC<=PC, IfIdValid<=1.
  - PC<=PC+4, or PC<=RESET_PC when PC+4 > IMEM_BYTES-4 (wrap).
  - Latency: the instruction at PC appears on IfIdInstr one cycle after PC is presented.
- Stall=1, Redirect=0: PC, IfIdInstr, IfIdPC and IfIdValid all hold.
- Redirect=1 with a legal target (RedirectTarget[1:0]==0 and RedirectTarget <= IMEM_BYTES-4):
  - PC<=RedirectTarget and IfIdValid<=0, which flushes the wrong-path word.
  - IfIdInstr and IfIdPC may hold any value.
  - Applies even if Stall=1.
- Redirect=1 with an illegal target: AddrFault<=1, IfIdValid<=0, PC holds, state<=HALT.
- Redirect and Stall in BOOT or HALT are ignored.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronous), and the sequence restarts in BOOT.
- All PC arithmetic is 32-bit unsigned. PC is never misaligned.

Optional Feature:
FETCH_HALT_DETECT_EN
- Defined: on a sequential advance in RUN where InstructionCode==HALT_WORD:
  - the word is latched with IfIdValid=1 in that cycle;
  - state<=HALT and PC holds.
  - On the next cycle IfIdValid=0 and Halted=1.
  - Redirect in the same cycle takes priority and no halt occurs.
- Not defined: HALT_WORD is fetched as an ordinary instruction. HALT is reachable only through AddrFault.

Decomposition:
- Package fetch_pkg:
  - state enum {BOOT, RUN, HALT};
  - PC_STEP=4;
  - default HALT_WORD constant;
  - a legal-target check function (alignment plus bound).
- One sub-module is natural: if_id_reg. It holds the IF/ID latch with load/hold/flush controls and async active-low clear.
- PC register, next-PC mux and FSM stay in fetch_pc_unit.

Test Plan:
- Reset low then release, memory words W0..W8 at 0..32, Stall=0 → BOOT cycle with IfIdValid=0 and PC=0. Then on successive cycles IfIdPC=0,4,8… and IfIdInstr=W0,W1… with IfIdValid=1.
- Run to PC=32 → the next PC is 0 (wrap), and IfIdPC=32 carries W8.
- Stall=1 for 3 cycles at PC=12 → PC stays 12, IfIdInstr stays W2, IfIdValid stays 1. Stall release → W3 is latched.
- Redirect=1, RedirectTarget=20, with Stall=1 at PC=8 → next cycle PC=20 and IfIdValid=0. The cycle after, IfIdInstr=W5 and IfIdPC=20.
- Redirect with target 22 (misaligned), then a separate run with target 36 (out of range) → each gives AddrFault=1, Halted=1, PC frozen, IfIdValid=0 until Reset. Reset low mid-HALT clears all outputs.
- With FETCH_HALT_DETECT_EN defined and W4=32'hFFFF_FFFF → IfIdInstr=FFFF_FFFF with IfIdValid=1 for one cycle, then Halted=1, PC=16 held. Without the macro, fetch continues to PC=20.
